wb_regfile_stage: RTL and testbench
===================================

# wb_regfile_stage

Writeback stage and architectural register file, at the consuming end of the MEM/WB pipeline buffer. Takes the buffer's registered outputs, selects the writeback value (memory data or ALU result), and commits it to a 32x32 register file at the clock edge. Provides two bypassed read ports to the decode stage and a forwarding value to execute. Also tracks the PC of the last retired instruction and, optionally, retire and stall counters.

## Interface
Parameters:
- `RESET_SP`, default `32'h0000_0000`: value loaded into register 29 on reset; every other register resets to 0.
- `CNT_W`, default `32`: width of the performance counters.

Ports (the only decided choice: one clock, `Clk`; reset `Reset_n`, asynchronous, active-low):
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset_n`  in  1  asynchronous active-low reset.
- `wb_instruction_in`  in  32  instruction in WB; `0` = bubble.
- `wb_regWrite_in`  in  1  instruction writes a GPR.
- `wb_NoWrite_in`  in  1  suppresses the write (conditional move not taken).
- `wb_MemRead_in`  in  1  1 = write back memory data, 0 = write back ALU result.
- `wb_dataMem_in`  in  32  load data.
- `wb_ALUoutput_in`  in  32  ALU / HI-LO result.
- `wb_writeReg_in`  in  5  destination register index.
- `wb_IF_Stall_in`  in  1  WB slot holds a stall bubble.
- `wb_PCounter_in`  in  32  PC of the WB instruction.
- `readReg1_in`, `readReg2_in`  in  5  decode-stage read indices.
- `readData1_out`, `readData2_out`  out  32  read data, bypassed.
- `writeData_out`  out  32  selected writeback value, for EX forwarding.
- `writeEn_out`  out  1  qualified write enable, for the hazard unit.
- `lastPC_out`  out  32  PC of the most recently retired instruction.
- `retireCount_out`, `stallCount_out`  out  CNT_W  performance counters (present only with the macro).

## Operation
- The writeback value is `writeData_out = wb_MemRead_in ? wb_dataMem_in : wb_ALUoutput_in`. It is combinational.
- `writeEn_out = wb_regWrite_in & ~wb_NoWrite_in & ~wb_IF_Stall_in & (wb_writeReg_in != 0)`.
- On the rising edge with `writeEn_out=1`: `gpr[wb_writeReg_in] <= writeData_out`.
- Register 0 is hardwired to 0. A write to it is discarded, and reads of it return 0.
- The read ports are combinational with write-first bypass. If `readRegN_in == wb_writeReg_in`, the index is nonzero and `writeEn_out=1`, then `readDataN_out = writeData_out`. Otherwise it returns `gpr[readRegN_in]`.
- Both ports may read the same index, including the index being written, and both get the same value.
- Retire condition: `~wb_IF_Stall_in & (wb_instruction_in != 0)`. Retirement does not depend on `regWrite`; stores and branches retire.
- On retire, `lastPC_out <= wb_PCounter_in`.

## Timing
- Reset (asynchronous assert, synchronous-to-`Clk` release):
  - all GPRs = 0, except `gpr[29] = RESET_SP`;
  - `lastPC_out = 0`;
  - counters = 0.
- Reset asserted mid-operation overrides any write in the same cycle. The next write commits on the first rising edge after deassertion.
- Write latency: the value is visible in the array one edge after WB. Through the bypass it is visible in the same cycle, so decode needs zero added stall.
- The combinational outputs (`writeData_out`, `writeEn_out`, `readData*_out`) have no registered delay.
- `lastPC_out` and the counters update on the same edge as the retire.
- There is no handshake. The WB slot is consumed every cycle; the stage never stalls upstream.

## Configuration
- `WB_PERF_CNT_EN` defined:
  - `retireCount_out` increments on each retire cycle.
  - `stallCount_out` increments on each cycle with `wb_IF_Stall_in=1`.
  - Both counters saturate at all-ones and never wrap.
  - The two counters cannot increment in the same cycle.
- Not defined: both ports are absent and no counter logic is synthesized. The remaining behaviour is identical.

## Test plan
- Reset with `RESET_SP=32'h7FFF_EFFC`, then read regs 0, 29 and 31 -> `0`, `7FFFEFFC`, `0`. `lastPC_out=0`.
- WB `regWrite=1, MemRead=0, ALUoutput=0x1234, writeReg=8`, with `readReg1_in=8` in the same cycle -> `readData1_out=0x1234` before the edge, and `gpr[8]=0x1234` after it.
- Load: `MemRead=1, dataMem=0xCAFEBABE, ALUoutput=0x10, writeReg=9` -> `writeData_out=0xCAFEBABE`, `gpr[9]` updated. Repeat with `NoWrite=1` and with `IF_Stall=1` -> `gpr[9]` unchanged and `writeEn_out=0`.
- Write `0xFFFF` to reg 0 -> `readData1_out`/`readData2_out` with index 0 return 0, and `writeEn_out=0`.
- With `WB_PERF_CNT_EN`:
  - 5 retiring instructions (PCs `0x0` to `0x10`), 2 stall cycles, 1 zero-instruction bubble -> `retireCount=5`, `stallCount=2`, `lastPC_out=0x10`.
  - Preload `CNT_W=4` and retire 20 instructions -> `retireCount_out` saturates at `4'hF`.
- Assert `Reset_n=0` for half a cycle between edges during a write burst -> all outputs reset immediately, the write on the following edge does not commit, and normal writes resume after release.

Source files
------------

// File: rtl/wb_regfile_stage_if.sv
// WB slot, decode read ports and writeback/retire outputs of wb_regfile_stage.
// The stage drives through the slave modport. The pipeline, decode and hazard logic drive through master.
interface wb_regfile_stage_if;
  logic [31:0] wb_instruction_in;
  logic        wb_regWrite_in;
  logic        wb_NoWrite_in;
  logic        wb_MemRead_in;
  logic [31:0] wb_dataMem_in;
  logic [31:0] wb_ALUoutput_in;
  logic [4:0]  wb_writeReg_in;
  logic        wb_IF_Stall_in;
  logic [31:0] wb_PCounter_in;
  logic [4:0]  readReg1_in;
  logic [4:0]  readReg2_in;
  logic [31:0] readData1_out;
  logic [31:0] readData2_out;
  logic [31:0] writeData_out;
  logic        writeEn_out;
  logic [31:0] lastPC_out;

  modport slave (
    input  wb_instruction_in, wb_regWrite_in, wb_NoWrite_in, wb_MemRead_in,
           wb_dataMem_in, wb_ALUoutput_in, wb_writeReg_in, wb_IF_Stall_in,
           wb_PCounter_in, readReg1_in, readReg2_in,
    output readData1_out, readData2_out, writeData_out, writeEn_out, lastPC_out
  );

  modport master (
    output wb_instruction_in, wb_regWrite_in, wb_NoWrite_in, wb_MemRead_in,
           wb_dataMem_in, wb_ALUoutput_in, wb_writeReg_in, wb_IF_Stall_in,
           wb_PCounter_in, readReg1_in, readReg2_in,
    input  readData1_out, readData2_out, writeData_out, writeEn_out, lastPC_out
  );
endinterface

// File: rtl/wb_regfile_stage.sv
// Writeback stage and 32x32 architectural register file with write-first bypassed read ports.
// Optional retire/stall counters are present when WB_PERF_CNT_EN is defined.
module wb_regfile_stage #(
  parameter logic [31:0] RESET_SP = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input logic               Clk,
  input logic               Reset_n,
  wb_regfile_stage_if.slave wb
`ifdef WB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  retireCount_out,
  output logic [CNT_W-1:0]  stallCount_out
`endif
);

  // There is no valid/ready handshake: the WB slot is consumed every cycle
  // and the stage never back-pressures the MEM/WB buffer.

  logic [31:0] gpr_q [0:31];
  logic [31:0] last_pc_q, last_pc_d;
  logic [31:0] write_data;
  logic        write_en;
  logic        retire;

  always_comb begin
    write_data = wb.wb_MemRead_in ? wb.wb_dataMem_in : wb.wb_ALUoutput_in;
    write_en   = wb.wb_regWrite_in & ~wb.wb_NoWrite_in & ~wb.wb_IF_Stall_in &
                 (wb.wb_writeReg_in != 5'd0);
    retire     = ~wb.wb_IF_Stall_in & (wb.wb_instruction_in != 32'd0);
  end

  assign wb.writeData_out = write_data;
  assign wb.writeEn_out   = write_en;

  // Bypass lets decode see the value being committed this cycle with no stall.
  always_comb begin
    wb.readData1_out = gpr_q[wb.readReg1_in];
    if (wb.readReg1_in == 5'd0) begin
      wb.readData1_out = 32'd0;
    end else if (write_en && (wb.readReg1_in == wb.wb_writeReg_in)) begin
      wb.readData1_out = write_data;
    end
  end

  always_comb begin
    wb.readData2_out = gpr_q[wb.readReg2_in];
    if (wb.readReg2_in == 5'd0) begin
      wb.readData2_out = 32'd0;
    end else if (write_en && (wb.readReg2_in == wb.wb_writeReg_in)) begin
      wb.readData2_out = write_data;
    end
  end

  // Register 0 is never written because write_en excludes index 0.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 32; i++) begin
        gpr_q[i] <= (i == 29) ? RESET_SP : 32'd0;
      end
    end else if (write_en) begin
      gpr_q[wb.wb_writeReg_in] <= write_data;
    end
  end

  always_comb begin
    last_pc_d = last_pc_q;
    if (retire) begin
      last_pc_d = wb.wb_PCounter_in;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      last_pc_q <= 32'd0;
    end else begin
      last_pc_q <= last_pc_d;
    end
  end

  assign wb.lastPC_out = last_pc_q;

`ifdef WB_PERF_CNT_EN
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Retire requires no stall, so at most one counter moves per cycle.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (retire && (retire_cnt_q != '1)) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
    if (wb.wb_IF_Stall_in && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign retireCount_out = retire_cnt_q;
  assign stallCount_out  = stall_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_wb_regfile_stage.sv
// Self-checking bench for wb_regfile_stage. Counter scenarios build only with WB_PERF_CNT_EN.
module tb_wb_regfile_stage;
  localparam logic [31:0] SP = 32'h7FFF_EFFC;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] model_gpr [0:31];
  logic [31:0] model_pc;
  logic [31:0] exp_q[$];

  wb_regfile_stage_if bus();

`ifdef WB_PERF_CNT_EN
  logic [31:0] retire_cnt;
  logic [31:0] stall_cnt;
  logic [3:0]  retire_cnt4;
  logic [3:0]  stall_cnt4;
  wb_regfile_stage_if bus4();

  wb_regfile_stage #(.RESET_SP(SP), .CNT_W(32)) dut (
    .Clk(clk), .Reset_n(rst_n), .wb(bus.slave),
    .retireCount_out(retire_cnt), .stallCount_out(stall_cnt)
  );

  assign bus4.wb_instruction_in = bus.wb_instruction_in;
  assign bus4.wb_regWrite_in    = bus.wb_regWrite_in;
  assign bus4.wb_NoWrite_in     = bus.wb_NoWrite_in;
  assign bus4.wb_MemRead_in     = bus.wb_MemRead_in;
  assign bus4.wb_dataMem_in     = bus.wb_dataMem_in;
  assign bus4.wb_ALUoutput_in   = bus.wb_ALUoutput_in;
  assign bus4.wb_writeReg_in    = bus.wb_writeReg_in;
  assign bus4.wb_IF_Stall_in    = bus.wb_IF_Stall_in;
  assign bus4.wb_PCounter_in    = bus.wb_PCounter_in;
  assign bus4.readReg1_in       = bus.readReg1_in;
  assign bus4.readReg2_in       = bus.readReg2_in;

  wb_regfile_stage #(.RESET_SP(SP), .CNT_W(4)) dut4 (
    .Clk(clk), .Reset_n(rst_n), .wb(bus4.slave),
    .retireCount_out(retire_cnt4), .stallCount_out(stall_cnt4)
  );
`else
  wb_regfile_stage #(.RESET_SP(SP), .CNT_W(32)) dut (
    .Clk(clk), .Reset_n(rst_n), .wb(bus.slave)
  );
`endif

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model_gpr[i] = (i == 29) ? SP : 32'd0;
    model_pc = 32'd0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver ----------------
  task automatic drive_wb(input logic [31:0] instr, input logic rw, nw, mr,
                          input logic [31:0] dmem, alu, input logic [4:0] wr,
                          input logic stall, input logic [31:0] pc);
    bus.wb_instruction_in = instr;
    bus.wb_regWrite_in    = rw;
    bus.wb_NoWrite_in     = nw;
    bus.wb_MemRead_in     = mr;
    bus.wb_dataMem_in     = dmem;
    bus.wb_ALUoutput_in   = alu;
    bus.wb_writeReg_in    = wr;
    bus.wb_IF_Stall_in    = stall;
    bus.wb_PCounter_in    = pc;
  endtask

  task automatic drive_idle();
    drive_wb(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
  endtask

  task automatic set_read(input logic [4:0] r1, r2);
    bus.readReg1_in = r1;
    bus.readReg2_in = r2;
  endtask

  function automatic logic model_en();
    return bus.wb_regWrite_in && !bus.wb_NoWrite_in && !bus.wb_IF_Stall_in &&
           (bus.wb_writeReg_in != 5'd0);
  endfunction

  function automatic logic [31:0] model_wdata();
    return bus.wb_MemRead_in ? bus.wb_dataMem_in : bus.wb_ALUoutput_in;
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (model_en() && idx == bus.wb_writeReg_in) return model_wdata();
    return model_gpr[idx];
  endfunction

  // Advance one clock edge and update the model with what the slot held.
  task automatic step();
    logic        en;
    logic        ret;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [31:0] pc;
    en  = model_en();
    wd  = model_wdata();
    wr  = bus.wb_writeReg_in;
    pc  = bus.wb_PCounter_in;
    ret = !bus.wb_IF_Stall_in && (bus.wb_instruction_in != 32'd0);
    @(posedge clk);
    if (rst_n) begin
      if (en) model_gpr[wr] = wd;
      if (ret) model_pc = pc;
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    drive_idle();
    set_read(5'd0, 5'd29);
    #2;
    checks++;
    if (bus.readData1_out !== 32'd0) begin
      errors++; $display("FAIL reset_r0 got=%h exp=%h", bus.readData1_out, 32'd0);
    end
    checks++;
    if (bus.readData2_out !== SP) begin
      errors++; $display("FAIL reset_r29 got=%h exp=%h", bus.readData2_out, SP);
    end
    set_read(5'd31, 5'd8);
    #1;
    checks++;
    if (bus.readData1_out !== 32'd0) begin
      errors++; $display("FAIL reset_r31 got=%h exp=%h", bus.readData1_out, 32'd0);
    end
    checks++;
    if (bus.lastPC_out !== 32'd0) begin
      errors++; $display("FAIL reset_lastpc got=%h exp=%h", bus.lastPC_out, 32'd0);
    end
    checks++;
    if (bus.writeEn_out !== 1'b0) begin
      errors++; $display("FAIL reset_wen got=%b exp=0", bus.writeEn_out);
    end
  endtask

  task automatic test_alu_bypass();
    drive_wb(32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'hDEAD_0000, 32'h0000_1234, 5'd8, 1'b0, 32'h4);
    set_read(5'd8, 5'd0);
    #2;
    checks++;
    if (bus.readData1_out !== 32'h1234) begin
      errors++; $display("FAIL alu_bypass got=%h exp=%h", bus.readData1_out, 32'h1234);
    end
    checks++;
    if (bus.writeEn_out !== 1'b1) begin
      errors++; $display("FAIL alu_wen got=%b exp=1", bus.writeEn_out);
    end
    step();
    drive_idle();
    #2;
    checks++;
    if (bus.readData1_out !== 32'h1234) begin
      errors++; $display("FAIL alu_commit got=%h exp=%h", bus.readData1_out, 32'h1234);
    end
  endtask

  task automatic test_load();
    drive_wb(32'h0000_0002, 1'b1, 1'b0, 1'b1, 32'hCAFE_BABE, 32'h10, 5'd9, 1'b0, 32'h8);
    set_read(5'd9, 5'd9);
    #2;
    checks++;
    if (bus.writeData_out !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL load_wdata got=%h exp=%h", bus.writeData_out, 32'hCAFE_BABE);
    end
    step();
    drive_idle();
    #2;
    checks++;
    if (bus.readData2_out !== 32'hCAFE_BABE) begin
      errors++; $display("FAIL load_commit got=%h exp=%h", bus.readData2_out, 32'hCAFE_BABE);
    end
    // NoWrite then IF_Stall: neither may touch reg 9.
    for (int k = 0; k < 2; k++) begin
      drive_wb(32'h0000_0003, 1'b1, (k == 0), 1'b1, 32'h5555_AAAA, 32'h20, 5'd9, (k == 1), 32'hC);
      #2;
      checks++;
      if (bus.writeEn_out !== 1'b0) begin
        errors++; $display("FAIL load_suppress_wen case=%0d got=%b exp=0", k, bus.writeEn_out);
      end
      checks++;
      if (bus.readData1_out !== 32'hCAFE_BABE) begin
        errors++; $display("FAIL load_suppress_bypass case=%0d got=%h exp=%h", k, bus.readData1_out, 32'hCAFE_BABE);
      end
      step();
      drive_idle();
      #2;
      checks++;
      if (bus.readData1_out !== 32'hCAFE_BABE) begin
        errors++; $display("FAIL load_suppress_keep case=%0d got=%h exp=%h", k, bus.readData1_out, 32'hCAFE_BABE);
      end
    end
  endtask

  task automatic test_reg0();
    drive_wb(32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0000_FFFF, 5'd0, 1'b0, 32'h10);
    set_read(5'd0, 5'd0);
    #2;
    checks++;
    if (bus.writeEn_out !== 1'b0) begin
      errors++; $display("FAIL reg0_wen got=%b exp=0", bus.writeEn_out);
    end
    checks++;
    if (bus.readData1_out !== 32'd0 || bus.readData2_out !== 32'd0) begin
      errors++; $display("FAIL reg0_bypass got=%h/%h exp=0", bus.readData1_out, bus.readData2_out);
    end
    step();
    drive_idle();
    #2;
    checks++;
    if (bus.readData1_out !== 32'd0 || bus.readData2_out !== 32'd0) begin
      errors++; $display("FAIL reg0_commit got=%h/%h exp=0", bus.readData1_out, bus.readData2_out);
    end
  endtask

  task automatic test_lastpc();
    drive_wb(32'h0000_00AA, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h40);
    step();
    drive_wb(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h80);
    step();
    drive_wb(32'h0000_00BB, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'hC0);
    step();
    drive_idle();
    #2;
    checks++;
    if (bus.lastPC_out !== 32'h40) begin
      errors++; $display("FAIL lastpc got=%h exp=%h", bus.lastPC_out, 32'h40);
    end
  endtask

  task automatic test_same_index();
    drive_wb(32'h0000_0005, 1'b1, 1'b0, 1'b0, 32'd0, 32'h0BAD_F00D, 5'd17, 1'b0, 32'h44);
    set_read(5'd17, 5'd17);
    #2;
    checks++;
    if (bus.readData1_out !== 32'h0BAD_F00D || bus.readData2_out !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL same_index got=%h/%h exp=%h", bus.readData1_out, bus.readData2_out, 32'h0BAD_F00D);
    end
    step();
  endtask

  // Scoreboard: expected read data is pushed when the slot is driven, popped once settled.
  task automatic test_random();
    logic [4:0] r1, r2, wr;
    logic [31:0] g1, g2, e1, e2;
    for (int n = 0; n < 40; n++) begin
      wr = 5'($urandom_range(0, 31));
      drive_wb(($urandom_range(0, 7) == 0) ? 32'd0 : $urandom(),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 1)), $urandom(), $urandom(), wr,
               1'($urandom_range(0, 7) == 0), $urandom() & 32'hFFFF_FFFC);
      r1 = ($urandom_range(0, 1) == 1) ? wr : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      set_read(r1, r2);
      exp_q.push_back(model_rd(r1));
      exp_q.push_back(model_rd(r2));
      #2;
      g1 = bus.readData1_out;
      g2 = bus.readData2_out;
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      checks++;
      if (g1 !== e1) begin
        errors++; $display("FAIL random_rd1 n=%0d idx=%0d got=%h exp=%h", n, r1, g1, e1);
      end
      checks++;
      if (g2 !== e2) begin
        errors++; $display("FAIL random_rd2 n=%0d idx=%0d got=%h exp=%h", n, r2, g2, e2);
      end
      step();
    end
    drive_idle();
    #2;
    checks++;
    if (bus.lastPC_out !== model_pc) begin
      errors++; $display("FAIL random_lastpc got=%h exp=%h", bus.lastPC_out, model_pc);
    end
  endtask

  task automatic test_reset_midburst();
    drive_wb(32'h0000_0006, 1'b1, 1'b0, 1'b0, 32'd0, 32'h1111_0001, 5'd12, 1'b0, 32'h50);
    step();
    drive_wb(32'h0000_0007, 1'b1, 1'b0, 1'b0, 32'd0, 32'h2222_0002, 5'd13, 1'b0, 32'h54);
    set_read(5'd12, 5'd29);
    #5;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.lastPC_out !== 32'd0) begin
      errors++; $display("FAIL midrst_lastpc got=%h exp=0", bus.lastPC_out);
    end
    checks++;
    if (bus.readData1_out !== 32'd0 || bus.readData2_out !== SP) begin
      errors++; $display("FAIL midrst_regs got=%h/%h exp=0/%h", bus.readData1_out, bus.readData2_out, SP);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive_idle();
    set_read(5'd13, 5'd12);
    #2;
    checks++;
    if (bus.readData1_out !== 32'd0 || bus.readData2_out !== 32'd0) begin
      errors++; $display("FAIL midrst_nocommit got=%h/%h exp=0/0", bus.readData1_out, bus.readData2_out);
    end
    drive_wb(32'h0000_0008, 1'b1, 1'b0, 1'b0, 32'd0, 32'h3333_0003, 5'd13, 1'b0, 32'h58);
    step();
    drive_idle();
    #2;
    checks++;
    if (bus.readData1_out !== 32'h3333_0003 || bus.lastPC_out !== 32'h58) begin
      errors++; $display("FAIL midrst_resume got=%h pc=%h exp=%h pc=%h", bus.readData1_out, bus.lastPC_out, 32'h3333_0003, 32'h58);
    end
  endtask

`ifdef WB_PERF_CNT_EN
  task automatic test_perf_cnt();
    drive_idle();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_wb(32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'(i * 4));
      step();
    end
    for (int i = 0; i < 2; i++) begin
      drive_wb(32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b1, 32'h100);
      step();
    end
    drive_wb(32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h200);
    step();
    drive_idle();
    #2;
    checks++;
    if (retire_cnt !== 32'd5 || stall_cnt !== 32'd2 || bus.lastPC_out !== 32'h10) begin
      errors++; $display("FAIL perf_counts got=%0d/%0d pc=%h exp=5/2 pc=10", retire_cnt, stall_cnt, bus.lastPC_out);
    end
    for (int i = 0; i < 20; i++) begin
      drive_wb(32'h0000_0021, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'h300 + 32'(i * 4));
      step();
    end
    drive_idle();
    #2;
    checks++;
    if (retire_cnt4 !== 4'hF || stall_cnt4 !== 4'd2) begin
      errors++; $display("FAIL perf_saturate got=%h/%h exp=f/2", retire_cnt4, stall_cnt4);
    end
    checks++;
    if (retire_cnt !== 32'd25) begin
      errors++; $display("FAIL perf_wide got=%0d exp=25", retire_cnt);
    end
  endtask
`endif

  // ---------------- sequencer / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    drive_idle();
    set_read(5'd0, 5'd0);
    apply_reset();
    test_reset();
    test_alu_bypass();
    test_load();
    test_reg0();
    test_lastpc();
    test_same_index();
    test_random();
    test_reset_midburst();
`ifdef WB_PERF_CNT_EN
    test_perf_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
